// File: rtl/serializer_fsm_if.sv
// Parallel-in / serial-out handshake bundle for serializer_fsm.
// master drives the upstream word and downstream ready; slave is the serializer.
interface serializer_fsm_if #(
   parameter int LENGTH = 32
);
   logic [LENGTH-1:0] iv_din;
   logic              i_din_valid;
   logic              o_ready;
   logic              i_ready;
   logic              o_dout;
   logic              o_dout_valid;
   logic              o_done;

   modport master (
      output iv_din, i_din_valid, i_ready,
      input  o_ready, o_dout, o_dout_valid, o_done
   );

   modport slave (
      input  iv_din, i_din_valid, i_ready,
      output o_ready, o_dout, o_dout_valid, o_done
   );
endinterface

// File: rtl/serializer_fsm.sv
// LSB-first word serializer: IDLE accepts a word, WAIT holds until downstream
// is ready, SHIFT streams LENGTH bits, DONE pulses once before returning to IDLE.
module serializer_fsm #(
   parameter int LENGTH = 32
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   serializer_fsm_if.slave bus
);
   localparam int CW = $clog2(LENGTH);
   localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SHIFT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [LENGTH-1:0] sr_q, sr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ready, dout_valid, done;

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      ready      = 1'b0;
      dout_valid = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (i_en && bus.i_din_valid) begin
               sr_d    = bus.iv_din;
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (i_en && bus.i_ready) state_d = SHIFT;
         end
         SHIFT: begin
            dout_valid = i_en;
            if (i_en) begin
               sr_d = sr_q >> 1;
               // counter is cleared on the last bit instead of wrapping past LENGTH-1
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            done = i_en;
            if (i_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_ready      = ready;
   assign bus.o_dout_valid = dout_valid;
   assign bus.o_done       = done;
   assign bus.o_dout       = sr_q[0];
endmodule

// File: tb/tb_serializer_fsm.sv
// Bench for serializer_fsm: directed scenarios plus random traffic, checked
// against a queue-of-bits reference model and a word-level reassembly check.
module tb_serializer_fsm;
   localparam int LEN = 32;

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic i_en;

   serializer_fsm_if #(.LENGTH(LEN)) bus ();

   serializer_fsm #(.LENGTH(LEN)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: pending bits of the current word
   bit           m_ready = 1'b1;
   bit           m_wait  = 1'b0;
   bit           m_done  = 1'b0;
   bit           m_bits[$];
   logic [LEN-1:0] m_word = '0;

   // observed-stream bookkeeping
   logic [LEN-1:0] rx_word = '0;
   int n_valid = 0;
   int n_done  = 0;
   int rx_idx  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_ready = 1'b1;
      m_wait  = 1'b0;
      m_done  = 1'b0;
      m_bits.delete();
      rx_idx  = 0;
   endtask

   task automatic cycle(input bit en_i, input bit rst_i, input bit dv_i,
                        input logic [LEN-1:0] din_i, input bit rdy_i);
      bit exp_valid;
      @(negedge i_clk);
      i_en            = en_i;
      i_rst_n         = rst_i;
      bus.i_din_valid = dv_i;
      bus.iv_din      = din_i;
      bus.i_ready     = rdy_i;
      #1;
      exp_valid = en_i && !m_wait && (m_bits.size() > 0);
      chk("ready", 64'(bus.o_ready), 64'(m_ready));
      chk("valid", 64'(bus.o_dout_valid), 64'(exp_valid));
      chk("done", 64'(bus.o_done), 64'(en_i && m_done));
      if (exp_valid) chk("dout", 64'(bus.o_dout), 64'(m_bits[0]));
      if (bus.o_dout_valid) begin
         if (rx_idx < LEN) rx_word[rx_idx] = bus.o_dout;
         rx_idx++;
         n_valid++;
      end
      if (bus.o_done) begin
         n_done++;
         chk("word", 64'(rx_word), 64'(m_word));
         chk("nbits", 64'(rx_idx), 64'(LEN));
         rx_idx = 0;
      end
      @(posedge i_clk);
      if (!rst_i) begin
         model_reset();
      end else if (en_i) begin
         if (m_done) begin
            m_done  = 1'b0;
            m_ready = 1'b1;
         end else if (m_wait) begin
            if (rdy_i) m_wait = 1'b0;
         end else if (m_bits.size() > 0) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_done = 1'b1;
         end else if (m_ready && dv_i) begin
            m_word  = din_i;
            for (int i = 0; i < LEN; i++) m_bits.push_back(din_i[i]);
            m_ready = 1'b0;
            m_wait  = 1'b1;
         end
      end
   endtask

   task automatic idle_until_done(input int budget);
      int start;
      start = n_done;
      for (int k = 0; k < budget && n_done == start; k++) cycle(1, 1, 0, '0, 1);
      chk("done_in_budget", 64'(n_done - start), 64'd1);
   endtask

   initial begin
      i_en            = 1'b0;
      i_rst_n         = 1'b0;
      bus.i_din_valid = 1'b0;
      bus.iv_din      = '0;
      bus.i_ready     = 1'b0;
      repeat (2) @(posedge i_clk);
      model_reset();
      #1;
      chk("rst_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_valid", 64'(bus.o_dout_valid), 64'd0);
      chk("rst_done", 64'(bus.o_done), 64'd0);
      chk("rst_dout", 64'(bus.o_dout), 64'd0);

      // 00FF00FF with downstream always ready
      n_valid = 0; n_done = 0;
      cycle(1, 1, 1, 32'h00FF00FF, 1);
      for (int k = 0; k < 40; k++) cycle(1, 1, 0, '0, 1);
      chk("ff00_valid_cnt", 64'(n_valid), 64'd32);
      chk("ff00_done_cnt", 64'(n_done), 64'd1);

      // A5A5A5A5 with downstream stalled for 20 cycles
      n_valid = 0; n_done = 0;
      cycle(1, 1, 1, 32'hA5A5A5A5, 0);
      for (int k = 0; k < 20; k++) cycle(1, 1, 1, 32'h0BAD0BAD, 0);
      chk("stall_no_valid", 64'(n_valid), 64'd0);
      idle_until_done(60);
      chk("a5_valid_cnt", 64'(n_valid), 64'd32);

      // 12345678 with a 5-cycle enable gap after bit 10
      n_valid = 0; n_done = 0;
      cycle(1, 1, 1, 32'h12345678, 1);
      for (int k = 0; k < 60 && n_valid < 11; k++) cycle(1, 1, 0, '0, 1);
      chk("reach_bit10", 64'(n_valid), 64'd11);
      for (int k = 0; k < 5; k++) cycle(0, 1, 1, 32'hDEADBEEF, 0);
      chk("gap_no_valid", 64'(n_valid), 64'd11);
      idle_until_done(60);
      chk("gap_valid_cnt", 64'(n_valid), 64'd32);

      // reset mid-word, then a full FFFFFFFF transfer
      n_valid = 0; n_done = 0;
      cycle(1, 1, 1, 32'hCAFEF00D, 1);
      for (int k = 0; k < 60 && n_valid < 17; k++) cycle(1, 1, 0, '0, 1);
      chk("reach_bit16", 64'(n_valid), 64'd17);
      cycle(1, 0, 0, '0, 1);
      #1;
      chk("abort_ready", 64'(bus.o_ready), 64'd1);
      chk("abort_valid", 64'(bus.o_dout_valid), 64'd0);
      for (int k = 0; k < 5; k++) cycle(1, 1, 0, '0, 1);
      chk("abort_no_done", 64'(n_done), 64'd0);
      n_valid = 0;
      cycle(1, 1, 1, 32'hFFFFFFFF, 1);
      idle_until_done(60);
      chk("ffff_valid_cnt", 64'(n_valid), 64'd32);

      // back-to-back words with din_valid held high
      n_done = 0;
      for (int k = 0; k < 3600 && n_done < 100; k++)
         cycle(1, 1, 1, LEN'($urandom), 1);
      chk("b2b_words", 64'(n_done), 64'd100);

      // fully random traffic including enable gaps, stalls and resets
      for (int k = 0; k < 4000; k++)
         cycle($urandom_range(0, 9) < 8, $urandom_range(0, 199) != 0,
               $urandom_range(0, 1) == 1, LEN'($urandom), $urandom_range(0, 1) == 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
